ecg_sample_scheduler: RTL
=========================

Name: ecg_sample_scheduler

Overview:
- Sequences the 32-bit ECG sample source into the wavelet-decomposition QRS pipeline.
- Generates a programmable sample-rate tick and pulses the source's advance enable on each tick.
- Buffers captured samples in a small FIFO and delivers them downstream over a valid/ready handshake.
- Tags analysis-window boundaries and counts samples dropped under backpressure.

Parameters:
- DATA_W, 32, sample width (matches ECG source output).
- DIV_W, 16, width of the sample-rate divider.
- WIN_LEN, 256, samples per analysis window (≥2).
- FIFO_DEPTH, 4, sample buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin acquisition (level sampled each cycle).
- stop  in  1  end acquisition, then drain buffered samples.
- div_cfg  in  DIV_W  clocks per sample; latched on start.
- src_en  out  1  one-cycle advance pulse to the ECG source.
- src_data  in  DATA_W  ECG source sample.
- m_valid  out  1  downstream sample valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  downstream sample.
- m_last  out  1  current m_data is the last sample of a window.
- win_done  out  1  one-cycle pulse after the last sample of a window is accepted.
- busy  out  1  state is not IDLE.
- ovf_cnt  out  16  dropped-sample count, saturating.
- state_o  out  2  FSM state (debug).

Behaviour:
- Reset (synchronous, any state):
  - state IDLE; FIFO flushed.
  - Divider, window index and ovf_cnt cleared.
  - All outputs 0.
- FSM states: IDLE=0, ARM=1, RUN=2, DRAIN=3.
- IDLE:
  - start=1 → ARM; latch div_cfg, with 0 treated as 1.
  - stop is ignored.
- ARM (exactly one cycle):
  - Clear window index, ovf_cnt and divider; divider loads latched_div-1.
  - stop=1 → DRAIN; otherwise → RUN.
- RUN:
  - Divider decrements each cycle. At 0 it issues a tick and reloads latched_div-1, so the first tick occurs latched_div cycles after leaving ARM.
  - On a tick: src_en=1 that cycle, and src_data is captured that same cycle.
  - Tick with FIFO not full, or full with a pop in the same cycle: push {tag, src_data}. tag=1 when window index == WIN_LEN-1. Window index then increments, wrapping to 0 after WIN_LEN-1.
  - Tick with FIFO full and no pop: sample dropped; ovf_cnt increments, saturating at 0xFFFF; window index unchanged.
  - stop=1 → DRAIN. A tick occurring in that same cycle is still taken.
  - start is ignored.
  - div_cfg changes are ignored until the next start.
- DRAIN:
  - No ticks; src_en=0.
  - FIFO empty → IDLE.
  - A partial window does not assert win_done.
- Downstream handshake:
  - m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
  - Transfer occurs when m_valid and m_ready are both 1.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Latency: sample captured at tick cycle t appears on m_data at t+1 when the FIFO was empty. Empty FIFO plus tick does not bypass.
- win_done: registered, asserted the cycle after a transfer with m_last=1.
- busy = (state != IDLE).
- Simultaneous push and pop: allowed at any occupancy, including full; occupancy is unchanged.

Decomposition:
- Package ecg_pkg:
  - state enum {IDLE, ARM, RUN, DRAIN} (2 bits).
  - ECG_DATA_W=32.
  - ECG_WIN_LEN default.
  - OVF_MAX=16'hFFFF.
- Sub-module ecg_sched_fifo:
  - Synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH.
  - Outputs full and empty, with registered head.
  - Push and pop in the same cycle permitted when full.
- FSM, divider, window counter and overflow counter live in the top level.

Test Plan:
- div_cfg=4, m_ready=1, src_data=ramp: src_en pulses every 4 cycles starting 4 cycles after ARM; each m_data equals src_data at its tick, one cycle later; ovf_cnt=0.
- div_cfg=1, m_ready=0, FIFO_DEPTH=4, 10 ticks: m_valid=1, m_data holds the first sample, ovf_cnt=6; after m_ready=1, exactly 4 samples transfer, in order.
- WIN_LEN=8, div_cfg=1, m_ready=1, 20 ticks: m_last on samples 8 and 16; win_done pulses twice, each the cycle after the transfer; no pulse for partial window of 4.
- stop with 3 queued and m_ready=0: state DRAIN, src_en stays 0, busy=1. Then raise m_ready: 3 transfers, state IDLE on the following cycle, busy=0.
- rst asserted in RUN with 2 queued: the following cycle m_valid=0, state_o=0, ovf_cnt=0, src_en=0. Then start: first tick resumes with window index 0.
- div_cfg=0 then start: ticks every cycle. Changing div_cfg to 5 mid-RUN leaves the tick rate unchanged until stop, drain and a new start.

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG sample scheduler.
package ecg_pkg;

    // Acquisition FSM; the encoding is visible on the state_o debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ecg_state_t;

    localparam int ECG_DATA_W     = 32;
    localparam int ECG_DIV_W      = 16;
    localparam int ECG_WIN_LEN    = 256;
    localparam int ECG_FIFO_DEPTH = 4;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    // Saturating increment for the dropped-sample counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == OVF_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ecg_sched_fifo.sv
// Small synchronous FIFO holding {window tag, sample}.
// Simultaneous push and pop is accepted at any occupancy, including full.
// The head is read straight out of the storage registers, so a word
// pushed into an empty FIFO becomes visible on the following cycle.
module ecg_sched_fifo
    import ecg_pkg::*;
#(
    parameter int WIDTH = ECG_DATA_W + 1,
    parameter int DEPTH = ECG_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ecg_sample_scheduler.sv
// Paces the ECG sample source with a programmable tick, buffers samples
// and hands them downstream, tagging the last sample of each window.
//
// Handshake: m_valid is high whenever the buffer holds a sample; a
// transfer happens on any cycle with m_valid and m_ready both high, and
// m_data/m_last hold steady while m_valid is high and m_ready is low.
module ecg_sample_scheduler
    import ecg_pkg::*;
#(
    parameter int DATA_W     = ECG_DATA_W,
    parameter int DIV_W      = ECG_DIV_W,
    parameter int WIN_LEN    = ECG_WIN_LEN,
    parameter int FIFO_DEPTH = ECG_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div_cfg,
    output logic              src_en,
    input  logic [DATA_W-1:0] src_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              win_done,
    output logic              busy,
    output logic [15:0]       ovf_cnt,
    output logic [1:0]        state_o
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    ecg_state_t        state;
    ecg_state_t        state_nxt;
    logic [DIV_W-1:0]  latched_div;
    logic [DIV_W-1:0]  div_cnt;
    logic [WIN_W-1:0]  win_idx;
    logic [15:0]       ovf_q;
    logic              win_done_q;

    logic              tick;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_wdata;
    logic [DATA_W:0]   fifo_rdata;

    assign tick       = (state == RUN) && (div_cnt == '0);
    assign pop        = !fifo_empty && m_ready;
    assign push       = tick && (!fifo_full || pop);
    assign drop       = tick && fifo_full && !pop;
    assign fifo_wdata = {(win_idx == WIN_LAST), src_data};

    assign src_en   = tick;
    assign m_valid  = !fifo_empty;
    assign m_data   = m_valid ? fifo_rdata[DATA_W-1:0] : '0;
    assign m_last   = m_valid && fifo_rdata[DATA_W];
    assign win_done = win_done_q;
    assign busy     = (state != IDLE);
    assign ovf_cnt  = ovf_q;
    assign state_o  = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: ARM lasts one cycle; DRAIN exits once the buffer is empty.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     state_nxt = stop ? DRAIN : RUN;
            RUN:     if (stop) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the divider on start; a zero divider means a tick every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched_div <= '0;
        end else if (state == IDLE && start) begin
            latched_div <= (div_cfg == '0) ? DIV_W'(1) : div_cfg;
        end
    end

    // Divider: loaded in ARM, counts down in RUN, ticks and reloads at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == ARM) begin
            div_cnt <= latched_div - DIV_W'(1);
        end else if (state == RUN) begin
            if (div_cnt == '0) begin
                div_cnt <= latched_div - DIV_W'(1);
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

    // Window index advances only on samples that actually enter the buffer.
    always_ff @(posedge clk) begin
        if (rst || state == ARM) begin
            win_idx <= '0;
        end else if (push) begin
            win_idx <= (win_idx == WIN_LAST) ? '0 : win_idx + WIN_W'(1);
        end
    end

    // Dropped-sample counter, saturating.
    always_ff @(posedge clk) begin
        if (rst || state == ARM) begin
            ovf_q <= '0;
        end else if (drop) begin
            ovf_q <= sat_inc(ovf_q);
        end
    end

    // Window-complete pulse, one cycle after the tagged sample is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_done_q <= 1'b0;
        end else begin
            win_done_q <= pop && fifo_rdata[DATA_W];
        end
    end

    ecg_sched_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
